// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
package game_pkg;

   typedef enum logic [2:0] {
      TITLE     = 3'b000,
      READY     = 3'b001,
      PLAYING   = 3'b010,
      PAUSED    = 3'b011,
      DYING     = 3'b100,
      CLEAR     = 3'b101,
      GAME_OVER = 3'b111
   } game_state_t;

   localparam int LIVES_W = 3;
   localparam int LEVEL_W = 4;

   // Default phase lengths at a 100 MHz system clock
   localparam int CLK_HZ      = 100_000_000;
   localparam int DEF_COLLIDE = 2 * CLK_HZ;
   localparam int DEF_READY   = CLK_HZ;
   localparam int DEF_DYING   = (3 * CLK_HZ) / 2;
   localparam int DEF_CLEAR   = 2 * CLK_HZ;

   function automatic int timer_w(int a, int b, int c, int d);
      int m;
      int w;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Control inputs and status outputs between conditioning and render logic.
interface game_flow_controller_if;
   import game_pkg::*;

   logic                start_i;
   logic                pause_i;
   logic                collision_i;
   logic                level_done_i;
   logic                ack_i;
   game_state_t         game_state_o;
   logic [LIVES_W-1:0]  lives_o;
   logic [LEVEL_W-1:0]  level_o;
   logic                won_o;
   logic                freeze_o;
   logic                respawn_o;
   logic                level_load_o;

   modport master (
      output start_i, pause_i, collision_i, level_done_i, ack_i,
      input  game_state_o, lives_o, level_o, won_o,
      input  freeze_o, respawn_o, level_load_o
   );

   modport slave (
      input  start_i, pause_i, collision_i, level_done_i, ack_i,
      output game_state_o, lives_o, level_o, won_o,
      output freeze_o, respawn_o, level_load_o
   );

endinterface

// File: rtl/game_flow_controller_phase_timer.sv
// phase_timer: loadable up-counter with clear, enable and terminal count.
module phase_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en)
         count <= count + 1'b1;
   end

   assign tc = (count == limit);

endmodule

// File: rtl/game_flow_controller.sv
// Game flow FSM: title, ready, play, pause, death, level clear, game over.
// Define EXTRA_LIFE_EN to award a life (max 7) on every level clear.
module game_flow_controller
   import game_pkg::*;
#(
   parameter int LIVES          = 3,
   parameter int LEVELS         = 4,
   parameter int COLLIDE_CYCLES = DEF_COLLIDE,
   parameter int READY_CYCLES   = DEF_READY,
   parameter int DYING_CYCLES   = DEF_DYING,
   parameter int CLEAR_CYCLES   = DEF_CLEAR
) (
   input  logic              clk_i,
   input  logic              reset,
   game_flow_controller_if.slave bus
);

   localparam int TW = timer_w(COLLIDE_CYCLES, READY_CYCLES,
                               DYING_CYCLES, CLEAR_CYCLES);

   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LEVELS - 1);

   game_state_t        state;
   logic [LIVES_W-1:0] lives;
   logic [LEVEL_W-1:0] level;
   logic               won;
   logic               freeze;
   logic               respawn;
   logic               level_load;
   logic               armed;

   logic               t_clr;
   logic               t_en;
   logic [TW-1:0]      t_limit;
   logic [TW-1:0]      t_count;
   logic               t_tc;

   phase_timer #(.W(TW)) u_timer (
      .clk      (clk_i),
      .rst      (reset),
      .clr      (t_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (t_en),
      .limit    (t_limit),
      .count    (t_count),
      .tc       (t_tc)
   );

   // Clearing on the terminal cycle guarantees a zero count on state entry
   always_comb begin
      t_clr   = 1'b1;
      t_en    = 1'b0;
      t_limit = '0;
      case (state)
         READY: begin
            t_limit = TW'(READY_CYCLES - 1);
            t_clr   = t_tc;
            t_en    = ~t_tc;
         end
         PLAYING: begin
            t_limit = TW'(COLLIDE_CYCLES - 1);
            t_clr   = bus.level_done_i | bus.pause_i
                    | ~bus.collision_i | t_tc;
            t_en    = ~t_clr;
         end
         DYING: begin
            t_limit = TW'(DYING_CYCLES - 1);
            t_clr   = t_tc;
            t_en    = ~t_tc;
         end
         CLEAR: begin
            t_limit = TW'(CLEAR_CYCLES - 1);
            t_clr   = t_tc;
            t_en    = ~t_tc;
         end
         default: begin
            t_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         state      <= TITLE;
         lives      <= LIVES_INIT;
         level      <= '0;
         won        <= 1'b0;
         freeze     <= 1'b1;
         respawn    <= 1'b0;
         level_load <= 1'b0;
         armed      <= 1'b0;
      end else begin
         respawn    <= 1'b0;
         level_load <= 1'b0;
         case (state)
            TITLE: begin
               armed <= armed | ~bus.start_i;
               if (bus.start_i && armed) begin
                  state      <= READY;
                  lives      <= LIVES_INIT;
                  level      <= '0;
                  won        <= 1'b0;
                  respawn    <= 1'b1;
                  level_load <= 1'b1;
               end
            end
            READY: begin
               if (t_tc) begin
                  state  <= PLAYING;
                  freeze <= 1'b0;
               end
            end
            PLAYING: begin
               if (bus.level_done_i) begin
                  state  <= CLEAR;
                  freeze <= 1'b1;
               end else if (bus.pause_i) begin
                  state  <= PAUSED;
                  freeze <= 1'b1;
               end else if (bus.collision_i && t_tc) begin
                  state  <= DYING;
                  freeze <= 1'b1;
               end
            end
            PAUSED: begin
               if (bus.pause_i) begin
                  state  <= PLAYING;
                  freeze <= 1'b0;
               end
            end
            DYING: begin
               if (t_tc) begin
                  if (lives != '0)
                     lives <= lives - 1'b1;
                  if (lives <= LIVES_W'(1)) begin
                     state <= GAME_OVER;
                     won   <= 1'b0;
                  end else begin
                     state   <= READY;
                     respawn <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               if (t_tc) begin
                  if (level >= LEVEL_LAST) begin
                     state <= GAME_OVER;
                     won   <= 1'b1;
                  end else begin
                     state      <= READY;
                     level      <= level + 1'b1;
                     respawn    <= 1'b1;
                     level_load <= 1'b1;
`ifdef EXTRA_LIFE_EN
                     if (lives != '1)
                        lives <= lives + 1'b1;
`endif
                  end
               end
            end
            GAME_OVER: begin
               if (bus.ack_i) begin
                  state <= TITLE;
                  armed <= 1'b0;
               end
            end
            default: begin
               state  <= TITLE;
               freeze <= 1'b1;
               armed  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.game_state_o = state;
   assign bus.lives_o      = lives;
   assign bus.level_o      = level;
   assign bus.won_o        = won;
   assign bus.freeze_o     = freeze;
   assign bus.respawn_o    = respawn;
   assign bus.level_load_o = level_load;

endmodule
